// File: rtl/game_pkg.sv
// Shared game constants, slot map and state encoding used by the obstacle
// scheduler and the drawing stage.
package game_pkg;

    localparam int SCREEN_W  = 640;
    localparam int OBST_W    = 120;
    localparam int X_HERO    = 120;
    localparam int NUM_SLOTS = 5;

    localparam int G0 = 0;
    localparam int G1 = 1;
    localparam int G2 = 2;
    localparam int B0 = 3;
    localparam int B1 = 4;

    localparam logic [NUM_SLOTS-1:0] GROUND_MASK = 5'b00111;
    localparam logic [NUM_SLOTS-1:0] BIRD_MASK   = 5'b11000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } slot_pick_t;

    // Lowest free slot of the wanted type, falling back to the other type.
    function automatic slot_pick_t pick_slot(input logic [NUM_SLOTS-1:0] busy,
                                             input logic                 want_bird);
        logic [NUM_SLOTS-1:0] type_mask;
        logic [NUM_SLOTS-1:0] free_pref;
        logic [NUM_SLOTS-1:0] free_other;
        logic [NUM_SLOTS-1:0] cand;
        slot_pick_t           pick;
        type_mask  = want_bird ? BIRD_MASK : GROUND_MASK;
        free_pref  = ~busy & type_mask;
        free_other = ~busy & ~type_mask;
        cand       = (free_pref != '0) ? free_pref : free_other;
        pick.found = (cand != '0);
        pick.idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick.idx = 3'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control inputs from the game FSM and obstacle positions toward the
// pixel-address mux.
interface obstacle_scheduler_if #(
    parameter int DATA_W = 32
);
    import game_pkg::*;

    logic                  frame_tick;
    logic                  start;
    logic                  hit;
    logic                  game_over;
    logic [DATA_W-1:0]     X_obst0;
    logic [DATA_W-1:0]     X_obst1;
    logic [DATA_W-1:0]     X_obst2;
    logic [DATA_W-1:0]     X_bird_obst0;
    logic [DATA_W-1:0]     X_bird_obst1;
    logic [NUM_SLOTS-1:0]  active;
    logic [3:0]            speed;
    logic                  showmode1;
    logic                  passed;

    modport master (
        output frame_tick, start, hit, game_over,
        input  X_obst0, X_obst1, X_obst2, X_bird_obst0, X_bird_obst1,
        input  active, speed, showmode1, passed
    );

    modport slave (
        input  frame_tick, start, hit, game_over,
        output X_obst0, X_obst1, X_obst2, X_bird_obst0, X_bird_obst1,
        output active, speed, showmode1, passed
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, advancing one step per enable.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame scroll, retire and spawn of ground/bird obstacles, with speed
// ramp, wing animation, freeze on game over and field clear on hit.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          SPAWN_X      = 760,
    parameter int          MIN_GAP      = 260,
    parameter int          SPEED_INIT   = 4,
    parameter int          SPEED_MAX    = 12,
    parameter int          SPEED_FRAMES = 600,
    parameter int          WING_FRAMES  = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    obstacle_scheduler_if.slave  bus
);

    localparam int SPD_CNT_W  = $clog2(SPEED_FRAMES + 1);
    localparam int WING_CNT_W = $clog2(WING_FRAMES + 1);

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    state_t                  state, state_nxt;
    logic [DATA_W-1:0]       x_p1 [NUM_SLOTS];
    logic [DATA_W-1:0]       x_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    act_p1, act_nxt;
    logic [DATA_W-1:0]       gap_p1, gap_nxt;
    logic [3:0]              speed_p1, speed_nxt;
    logic [SPD_CNT_W-1:0]    spd_cnt_p1, spd_cnt_nxt;
    logic [WING_CNT_W-1:0]   wing_cnt_p1, wing_cnt_nxt;
    logic                    show_p1, show_nxt;
    logic                    passed_p1, passed_nxt;

    logic                    tick_vld_p0;
    logic                    hit_vld_p0;
    logic [15:0]             lfsr_q;
    logic                    unused_lfsr_hi;
    logic [DATA_W-1:0]       speed_w;
    logic [DATA_W-1:0]       gap_dec;
    logic [DATA_W-1:0]       scroll_x;
    slot_pick_t              pick;

    // Stage p0: qualify events by state and priority
    assign tick_vld_p0 = (state == RUN) && bus.frame_tick && !bus.start
                         && !bus.game_over && !bus.hit;
    assign hit_vld_p0  = (state == RUN) && bus.hit && !bus.start && !bus.game_over;

    // The upper LFSR bits only feed the sequence itself.
    assign unused_lfsr_hi = ^lfsr_q[15:8];

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (tick_vld_p0),
        .q   (lfsr_q)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (bus.start) state_nxt = RUN;
                     else if (bus.game_over) state_nxt = FROZEN;
            FROZEN:  if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Free-slot search uses start-of-tick occupancy, so a slot freed by this
    // tick's retire is only reusable from the following tick on.
    always_comb begin
        x_nxt        = x_p1;
        act_nxt      = act_p1;
        gap_nxt      = gap_p1;
        speed_nxt    = speed_p1;
        spd_cnt_nxt  = spd_cnt_p1;
        wing_cnt_nxt = wing_cnt_p1;
        show_nxt     = show_p1;
        passed_nxt   = 1'b0;
        scroll_x     = '0;
        speed_w      = DATA_W'(speed_p1);
        gap_dec      = sat_sub(gap_p1, speed_w);
        pick         = pick_slot(act_p1, lfsr_q[1:0] == 2'b11);

        if (bus.start) begin
            for (int i = 0; i < NUM_SLOTS; i++) x_nxt[i] = '0;
            act_nxt      = '0;
            gap_nxt      = '0;
            speed_nxt    = 4'(SPEED_INIT);
            spd_cnt_nxt  = '0;
            wing_cnt_nxt = '0;
        end else if (hit_vld_p0) begin
            for (int i = 0; i < NUM_SLOTS; i++) x_nxt[i] = '0;
            act_nxt = '0;
            gap_nxt = DATA_W'(MIN_GAP);
        end else if (tick_vld_p0) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (act_p1[i]) begin
                    scroll_x = x_p1[i] - speed_w;
                    if (scroll_x <= speed_w) begin
                        x_nxt[i]   = '0;
                        act_nxt[i] = 1'b0;
                        passed_nxt = 1'b1;
                    end else begin
                        x_nxt[i] = scroll_x;
                    end
                end
            end

            gap_nxt = gap_dec;
            if ((gap_dec == '0) && pick.found) begin
                x_nxt[pick.idx]   = DATA_W'(SPAWN_X);
                act_nxt[pick.idx] = 1'b1;
                gap_nxt           = DATA_W'(MIN_GAP) + DATA_W'(lfsr_q[7:0]);
            end

            if (spd_cnt_p1 == SPD_CNT_W'(SPEED_FRAMES - 1)) begin
                spd_cnt_nxt = '0;
                if (speed_p1 < 4'(SPEED_MAX)) speed_nxt = speed_p1 + 4'd1;
            end else begin
                spd_cnt_nxt = spd_cnt_p1 + SPD_CNT_W'(1);
            end

            if (wing_cnt_p1 == WING_CNT_W'(WING_FRAMES - 1)) begin
                wing_cnt_nxt = '0;
                show_nxt     = ~show_p1;
            end else begin
                wing_cnt_nxt = wing_cnt_p1 + WING_CNT_W'(1);
            end
        end
    end

    // Stage p1: registered field state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) x_p1[i] <= '0;
            act_p1      <= '0;
            gap_p1      <= '0;
            speed_p1    <= 4'(SPEED_INIT);
            spd_cnt_p1  <= '0;
            wing_cnt_p1 <= '0;
            show_p1     <= 1'b0;
            passed_p1   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) x_p1[i] <= x_nxt[i];
            act_p1      <= act_nxt;
            gap_p1      <= gap_nxt;
            speed_p1    <= speed_nxt;
            spd_cnt_p1  <= spd_cnt_nxt;
            wing_cnt_p1 <= wing_cnt_nxt;
            show_p1     <= show_nxt;
            passed_p1   <= passed_nxt;
        end
    end

    assign bus.X_obst0      = x_p1[G0];
    assign bus.X_obst1      = x_p1[G1];
    assign bus.X_obst2      = x_p1[G2];
    assign bus.X_bird_obst0 = x_p1[B0];
    assign bus.X_bird_obst1 = x_p1[B1];
    assign bus.active       = act_p1;
    assign bus.speed        = speed_p1;
    assign bus.showmode1    = show_p1;
    assign bus.passed       = passed_p1;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: scenario tasks checked against a behavioural
// model of the obstacle field kept in plain arrays and integers.
module tb_obstacle_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obstacle_scheduler_if bus ();
    obstacle_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2;
    localparam logic [170:0] EXP_RST = {160'd0, 5'd0, 4'd4, 2'b00};

    int unsigned m_x [5];
    bit          m_act [5];
    int unsigned m_gap, m_speed, m_frames, m_wing, m_lfsr;
    bit          m_show, m_passed;
    int          m_mode;
    int          ticks_since;

    task automatic m_reset();
        for (int i = 0; i < 5; i++) begin m_x[i] = 0; m_act[i] = 0; end
        m_gap = 0; m_speed = 4; m_frames = 0; m_wing = 0; m_lfsr = 'hACE1;
        m_show = 0; m_passed = 0; m_mode = M_IDLE;
    endtask

    task automatic m_tick();
        bit          busy [5];
        bit          retired;
        int unsigned nx;
        int          order [5];
        retired = 0;
        busy = m_act;
        for (int i = 0; i < 5; i++) begin
            if (m_act[i]) begin
                nx = m_x[i] - m_speed;
                if (nx <= m_speed) begin m_x[i] = 0; m_act[i] = 0; retired = 1; end
                else m_x[i] = nx;
            end
        end
        m_gap = (m_gap > m_speed) ? m_gap - m_speed : 0;
        if (m_gap == 0) begin
            if ((m_lfsr % 4) == 3) order = '{3, 4, 0, 1, 2};
            else                   order = '{0, 1, 2, 3, 4};
            for (int k = 0; k < 5; k++) begin
                if (!busy[order[k]]) begin
                    m_x[order[k]] = 760; m_act[order[k]] = 1;
                    m_gap = 260 + (m_lfsr % 256);
                    break;
                end
            end
        end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
        m_frames++;
        if (m_frames == 600) begin m_frames = 0; if (m_speed < 12) m_speed++; end
        m_wing++;
        if (m_wing == 8) begin m_wing = 0; m_show = !m_show; end
        m_passed = retired;
    endtask

    task automatic m_step(bit st, bit fr, bit h, bit go);
        if (st) begin
            for (int i = 0; i < 5; i++) begin m_x[i] = 0; m_act[i] = 0; end
            m_gap = 0; m_speed = 4; m_frames = 0; m_wing = 0; m_passed = 0; m_mode = M_RUN;
        end else if (m_mode == M_RUN && go) begin
            m_mode = M_FROZEN; m_passed = 0;
        end else if (m_mode == M_RUN && h) begin
            for (int i = 0; i < 5; i++) begin m_x[i] = 0; m_act[i] = 0; end
            m_gap = 260; m_passed = 0;
        end else if (m_mode == M_RUN && fr) begin
            m_tick();
        end else begin
            m_passed = 0;
        end
    endtask

    function automatic logic [170:0] model_vec();
        logic [4:0] a;
        for (int i = 0; i < 5; i++) a[i] = m_act[i];
        return {m_x[0], m_x[1], m_x[2], m_x[3], m_x[4], a, m_speed[3:0], m_show, m_passed};
    endfunction

    function automatic logic [170:0] dut_vec();
        return {bus.X_obst0, bus.X_obst1, bus.X_obst2, bus.X_bird_obst0, bus.X_bird_obst1,
                bus.active, bus.speed, bus.showmode1, bus.passed};
    endfunction

    task automatic cyc(bit st, bit fr, bit h, bit go);
        bus.start = st; bus.frame_tick = fr; bus.hit = h; bus.game_over = go;
        m_step(st, fr, h, go);
        @(posedge clk); #1;
        bus.start = 0; bus.frame_tick = 0; bus.hit = 0;
    endtask

    task automatic do_reset();
        rst = 1; bus.start = 0; bus.frame_tick = 0; bus.hit = 0; bus.game_over = 0;
        m_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_vec() !== EXP_RST) begin
            fails++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), EXP_RST);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, (i == 1), 0);
            tests++;
            if (dut_vec() !== EXP_RST || dut_vec() !== model_vec()) begin
                fails++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, dut_vec(), EXP_RST);
            end
        end
    endtask

    task automatic test_first_spawn();
        int n;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        tests++;
        if (bus.X_obst0 !== 32'd760 || bus.active !== 5'b00001 || bus.speed !== 4'd4) begin
            fails++; $display("FAIL first_spawn got x=%0d act=%b spd=%0d exp x=760 act=00001 spd=4",
                              bus.X_obst0, bus.active, bus.speed);
        end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1, 0, 0);
            n++;
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL first_spawn_model tick=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if ($countones(bus.active) >= 2) break;
        end
        tests++;
        if (n != 122) begin
            fails++; $display("FAIL second_spawn_gap got=%0d ticks exp=122", n);
        end
        ticks_since = n;
    endtask

    task automatic test_scroll_retire();
        while (ticks_since < 188) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc(0, 0, 0, 0);
            cyc(0, 1, 0, 0);
            ticks_since++;
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL scroll_model tick=%0d got=%h exp=%h", ticks_since, dut_vec(), model_vec());
            end
        end
        tests++;
        if (bus.X_obst0 !== 32'd8) begin
            fails++; $display("FAIL scroll_pre_retire got=%0d exp=8", bus.X_obst0);
        end
        cyc(0, 1, 0, 0);
        tests++;
        if (bus.X_obst0 !== 32'd0 || bus.active[0] !== 1'b0 || bus.passed !== 1'b1) begin
            fails++; $display("FAIL retire got x=%0d act0=%b passed=%b exp x=0 act0=0 passed=1",
                              bus.X_obst0, bus.active[0], bus.passed);
        end
        cyc(0, 0, 0, 0);
        tests++;
        if (bus.passed !== 1'b0 || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL passed_width got=%b exp=0", bus.passed);
        end
    endtask

    task automatic test_speed_ramp();
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 5400; i++) begin
            cyc(0, 1, 0, 0);
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL ramp_model tick=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (i == 599 || i == 600 || i == 5400) begin
                tests++;
                if (bus.speed !== ((i == 599) ? 4'd4 : (i == 600) ? 4'd5 : 4'd12)) begin
                    fails++; $display("FAIL speed_ramp tick=%0d got=%0d", i, bus.speed);
                end
            end
        end
    endtask

    task automatic test_hit_collision();
        logic [3:0] s;
        int         n;
        bit         ok;
        cyc(1, 0, 0, 0);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(0, 1, 0, 0);
            if ($countones(bus.active) >= 2) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL hit_setup got=%0d active exp>=2", $countones(bus.active));
        end
        s = bus.speed;
        cyc(0, 1, 1, 0);
        tests++;
        if (dut_vec() !== {160'd0, 5'd0, s, bus.showmode1, 1'b0} || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL hit_clear got=%h exp=%h", dut_vec(), model_vec());
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(0, 1, 0, 0);
            n++;
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL hit_model tick=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (bus.active != 0) break;
        end
        tests++;
        if (n != (260 + int'(s) - 1) / int'(s)) begin
            fails++; $display("FAIL hit_gap got=%0d ticks exp=%0d", n, (260 + int'(s) - 1) / int'(s));
        end
    endtask

    task automatic test_freeze_restart();
        logic [170:0] snap;
        logic [31:0]  xs [5];
        int           nspawn;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 1) == 1) cyc(0, 0, 0, 0);
            cyc(0, 1, 0, 0);
        end
        cyc(0, 1, 0, 1);
        snap = dut_vec();
        tests++;
        if (snap !== model_vec()) begin
            fails++; $display("FAIL freeze_entry got=%h exp=%h", snap, model_vec());
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, (i == 4), 1);
            tests++;
            if (dut_vec() !== snap) begin
                fails++; $display("FAIL frozen_hold cyc=%0d got=%h exp=%h", i, dut_vec(), snap);
            end
        end
        cyc(1, 0, 0, 0);
        tests++;
        if (bus.active !== 5'd0 || bus.speed !== 4'd4 || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL restart_clear got=%h exp=%h", dut_vec(), model_vec());
        end
        cyc(0, 1, 0, 0);
        xs = '{bus.X_obst0, bus.X_obst1, bus.X_obst2, bus.X_bird_obst0, bus.X_bird_obst1};
        nspawn = 0;
        for (int i = 0; i < 5; i++) if (bus.active[i] && xs[i] == 32'd760) nspawn++;
        tests++;
        if (nspawn != 1 || $countones(bus.active) != 1 || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL restart_spawn got act=%b spawned=%0d exp one slot at 760", bus.active, nspawn);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        tests++;
        if (bus.active !== 5'd0 || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL start_over_tick got=%h exp=%h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        rst = 1; bus.frame_tick = 1;
        m_reset();
        @(posedge clk); #1;
        rst = 0; bus.frame_tick = 0;
        tests++;
        if (dut_vec() !== EXP_RST) begin
            fails++; $display("FAIL midrun_reset got=%h exp=%h", dut_vec(), EXP_RST);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        tests++;
        if (bus.X_obst0 !== 32'd760 || bus.active !== 5'b00001 || dut_vec() !== model_vec()) begin
            fails++; $display("FAIL reseed_spawn got x=%0d act=%b exp x=760 act=00001", bus.X_obst0, bus.active);
        end
    endtask

    task automatic test_random();
        bit go_lvl, st, fr, h;
        go_lvl = 0;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) go_lvl = !go_lvl;
            st = ($urandom_range(0, 999) == 0) || (m_mode == M_FROZEN && !go_lvl && $urandom_range(0, 19) == 0);
            fr = ($urandom_range(0, 2) != 0);
            h  = ($urandom_range(0, 149) == 0);
            cyc(st, fr, h, go_lvl);
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        bus.game_over = 0;
    endtask

    initial begin
        rst = 1;
        bus.start = 0; bus.frame_tick = 0; bus.hit = 0; bus.game_over = 0;
        ticks_since = 0;
        test_reset();
        test_first_spawn();
        test_scroll_retire();
        test_speed_ramp();
        test_hit_collision();
        test_freeze_restart();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
